mcpu_core_ws: RTL and testbench

Wait-state-capable, parametrised MCPU core. It keeps the 8-bit MOV/CMOV/IMM instruction set and the external ALU inputs of the single-cycle core. It adds three things: a data-RAM acknowledge handshake with stall, a fetch-valid and run-enable gate, and a halt state entered on the all-zero instruction. It also adds a retired-instruction counter. It sits between instruction ROM, data RAM/IO and an internal `mcpu_alu` instance.

---
 rtl/mcpu_core_ws_if.sv | 31 +++
 rtl/mcpu_core_ws.sv | 216 +++++++++++++++++++++
 tb/tb_mcpu_core_ws.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcpu_core_ws_if.sv
// Bus bundle between mcpu_core_ws and its instruction ROM, data RAM and external ALU operand sources.
interface mcpu_core_ws_if #(parameter int DATA_WIDTH = 32);
  logic                  run_en;
  logic [7:0]            irom_in;
  logic                  irom_valid;
  logic [DATA_WIDTH-1:0] cnt_pc;
  logic [DATA_WIDTH-1:0] reg_addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  dram_re;
  logic                  dram_we;
  logic                  dram_ack;
  logic                  sense;
  logic [DATA_WIDTH-1:0] alu_x;
  logic [DATA_WIDTH-1:0] alu_y;
  logic [DATA_WIDTH-1:0] reg_i;
  logic [DATA_WIDTH-1:0] reg_j;
  logic [DATA_WIDTH-1:0] reg_k;
  logic                  halted;
  logic [DATA_WIDTH-1:0] retired;

  modport master (
    input  run_en, irom_in, irom_valid, data_in, dram_ack, sense, alu_x, alu_y,
    output cnt_pc, reg_addr, data_out, dram_re, dram_we, reg_i, reg_j, reg_k, halted, retired
  );

  modport slave (
    output run_en, irom_in, irom_valid, data_in, dram_ack, sense, alu_x, alu_y,
    input  cnt_pc, reg_addr, data_out, dram_re, dram_we, reg_i, reg_j, reg_k, halted, retired
  );
endinterface

// File: rtl/mcpu_core_ws.sv
// MCPU core with data-RAM wait states, gated fetch, halt-on-zero and a retired-instruction counter.
// mcpu_alu: op[2:0] selects the result, op[3] selects the flag (zero result or sense input).
module mcpu_alu #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 42
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic                  sense,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  f_out
);
  logic w_unused_op;
  assign w_unused_op = ^op[OP_WIDTH-1:4];

  always_comb begin
    d_out = '0;
    case (op[2:0])
      3'd0: d_out = a + b;
      3'd1: d_out = a - b;
      3'd2: d_out = a & b;
      3'd3: d_out = a | b;
      3'd4: d_out = a ^ b;
      3'd5: d_out = ~a;
      3'd6: d_out = x;
      3'd7: d_out = y;
    endcase
  end

  assign f_out = op[3] ? (d_out == '0) : sense;
endmodule

// state    | meaning
// S_RUN    | accepting instructions when run_en & irom_valid
// S_WAIT   | memory access issued, holding strobes until dram_ack
// S_HALT   | stopped on 8'h00, left only by reset
module mcpu_core_ws #(
  parameter int DATA_WIDTH   = 32,
  parameter int IMM_STAGES   = 6,
  parameter int HALT_ON_ZERO = 1
) (
  input logic          clk,
  input logic          reset,
  mcpu_core_ws_if.master bus
);
  localparam int IMM_W = IMM_STAGES * 7;
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [2:0] SEL_PC   = 3'd0;
  localparam logic [2:0] SEL_ADDR = 3'd1;
  localparam logic [2:0] SEL_RAM  = 3'd2;
  localparam logic [2:0] SEL_IMM  = 3'd3;
  localparam logic [2:0] SEL_ALU  = 3'd4;
  localparam logic [2:0] DST_ALUA = 3'd3;
  localparam logic [2:0] DST_ALUB = 3'd4;
  localparam logic [2:0] SEL_I    = 3'd5;
  localparam logic [2:0] SEL_J    = 3'd6;
  localparam logic [2:0] SEL_K    = 3'd7;

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [IMM_W-1:0]      r_srg_imm;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [DATA_WIDTH-1:0] r_i;
  logic [DATA_WIDTH-1:0] r_j;
  logic [DATA_WIDTH-1:0] r_k;
  logic [DATA_WIDTH-1:0] r_retired;
  logic                  r_last_imm;
  logic [7:0]            r_winstr;
  logic                  r_wexec;

  logic                  w_in_run;
  logic                  w_in_wait;
  logic                  w_accept;
  logic                  w_active;
  logic [7:0]            w_instr;
  logic                  w_is_imm;
  logic                  w_cond;
  logic [2:0]            w_dst;
  logic [2:0]            w_src;
  logic                  w_alu_f;
  logic [DATA_WIDTH-1:0] w_alu_d;
  logic                  w_exec_now;
  logic                  w_exec;
  logic                  w_mem;
  logic                  w_halt_take;
  logic                  w_stall_entry;
  logic                  w_commit;
  logic [DATA_WIDTH-1:0] w_data_out;

  mcpu_alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .OP_WIDTH   (IMM_W)
  ) u_alu (
    .a     (r_alu_a),
    .b     (r_alu_b),
    .x     (bus.alu_x),
    .y     (bus.alu_y),
    .op    (r_srg_imm),
    .sense (bus.sense),
    .d_out (w_alu_d),
    .f_out (w_alu_f)
  );

  assign w_in_run  = (r_state == S_RUN);
  assign w_in_wait = (r_state == S_WAIT);
  assign w_accept  = w_in_run & bus.run_en & bus.irom_valid;
  assign w_active  = w_accept | w_in_wait;

  // While stalled the latched instruction and exec decision drive everything.
  assign w_instr    = w_in_wait ? r_winstr : bus.irom_in;
  assign w_is_imm   = w_instr[7];
  assign w_cond     = w_instr[6];
  assign w_dst      = w_instr[5:3];
  assign w_src      = w_instr[2:0];
  assign w_exec_now = ~w_is_imm & (~w_cond | w_alu_f);
  assign w_exec     = w_in_wait ? r_wexec : w_exec_now;
  assign w_mem      = w_exec & ((w_src == SEL_RAM) | (w_dst == SEL_RAM));

  assign w_halt_take   = w_accept & (HALT_ON_ZERO != 0) & (w_instr == 8'h00);
  assign w_stall_entry = w_accept & ~w_is_imm & ~w_halt_take & w_mem & ~bus.dram_ack;
  assign w_commit      = w_active & ~w_is_imm & ~w_halt_take & (~w_mem | bus.dram_ack);

  always_comb begin
    w_data_out = '0;
    case (w_src)
      SEL_PC:   w_data_out = r_pc;
      SEL_ADDR: w_data_out = r_addr;
      SEL_RAM:  w_data_out = bus.data_in;
      SEL_IMM:  w_data_out = r_srg_imm[DATA_WIDTH-1:0];
      SEL_ALU:  w_data_out = w_alu_d;
      SEL_I:    w_data_out = r_i;
      SEL_J:    w_data_out = r_j;
      SEL_K:    w_data_out = r_k;
    endcase
  end

  assign bus.data_out = w_data_out;
  assign bus.dram_re  = w_active & w_mem & (w_src == SEL_RAM);
  assign bus.dram_we  = w_active & w_mem & (w_dst == SEL_RAM);
  assign bus.cnt_pc   = r_pc;
  assign bus.reg_addr = r_addr;
  assign bus.reg_i    = r_i;
  assign bus.reg_j    = r_j;
  assign bus.reg_k    = r_k;
  assign bus.retired  = r_retired;
  assign bus.halted   = (r_state == S_HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_RUN;
      r_pc       <= '0;
      r_addr     <= '0;
      r_srg_imm  <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_retired  <= '0;
      r_last_imm <= 1'b0;
      r_winstr   <= '0;
      r_wexec    <= 1'b0;
    end else begin
      if (w_accept && w_is_imm) begin
        r_srg_imm  <= r_last_imm ? {r_srg_imm[IMM_W-8:0], w_instr[6:0]}
                                 : {{(IMM_W-7){1'b0}}, w_instr[6:0]};
        r_last_imm <= 1'b1;
        r_pc       <= r_pc + ONE;
        r_retired  <= r_retired + ONE;
      end

      if (w_commit) begin
        if (w_exec) begin
          case (w_dst)
            SEL_ADDR: r_addr  <= w_data_out;
            DST_ALUA: r_alu_a <= w_data_out;
            DST_ALUB: r_alu_b <= w_data_out;
            SEL_I:    r_i     <= w_data_out;
            SEL_J:    r_j     <= w_data_out;
            SEL_K:    r_k     <= w_data_out;
            default: ;
          endcase
        end
        r_pc       <= (w_exec && (w_dst == SEL_PC)) ? w_data_out : r_pc + ONE;
        r_last_imm <= 1'b0;
        r_retired  <= r_retired + ONE;
      end

      case (r_state)
        S_RUN: begin
          if (w_halt_take) begin
            r_state <= S_HALT;
          end else if (w_stall_entry) begin
            r_state  <= S_WAIT;
            r_winstr <= bus.irom_in;
            r_wexec  <= w_exec_now;
          end
        end
        S_WAIT: begin
          if (bus.dram_ack) r_state <= S_RUN;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mcpu_core_ws.sv
// Scoreboarded bench for mcpu_core_ws: an instruction-level model queues the architectural state
// expected after each completion, and a monitor compares it whenever the core retires or halts.
module tb_mcpu_core_ws;
  localparam int DW    = 32;
  localparam int IMM_W = 42;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mcpu_core_ws_if #(.DATA_WIDTH(DW)) bus ();

  mcpu_core_ws #(
    .DATA_WIDTH   (DW),
    .IMM_STAGES   (6),
    .HALT_ON_ZERO (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] addr;
    logic [DW-1:0] i;
    logic [DW-1:0] j;
    logic [DW-1:0] k;
    logic [DW-1:0] ret;
    logic          halted;
  } exp_t;

  exp_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Architectural model state
  logic [DW-1:0]    m_pc, m_addr, m_a, m_b, m_i, m_j, m_k, m_ret;
  logic [IMM_W-1:0] m_imm;
  logic             m_last, m_halt;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] x, input logic [DW-1:0] y,
                                            input logic [2:0] sel);
    case (sel)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return x;
      default: return y;
    endcase
  endfunction

  function automatic logic [DW-1:0] ref_src(input logic [2:0] s, input logic [DW-1:0] din,
                                            input logic [DW-1:0] x, input logic [DW-1:0] y);
    case (s)
      3'd0: return m_pc;
      3'd1: return m_addr;
      3'd2: return din;
      3'd3: return m_imm[DW-1:0];
      3'd4: return ref_alu(m_a, m_b, x, y, m_imm[2:0]);
      3'd5: return m_i;
      3'd6: return m_j;
      default: return m_k;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = '0; m_addr = '0; m_a = '0; m_b = '0; m_i = '0; m_j = '0; m_k = '0; m_ret = '0;
    m_imm = '0; m_last = 1'b0; m_halt = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_commit(input logic [7:0] ins, input logic ex, input logic [DW-1:0] v);
    if (ins[7]) begin
      if (m_last) m_imm = (m_imm << 7) | IMM_W'(ins[6:0]);
      else        m_imm = IMM_W'(ins[6:0]);
      m_last = 1'b1;
      m_pc   = m_pc + 1;
      m_ret  = m_ret + 1;
    end else if (ins == 8'h00) begin
      m_halt = 1'b1;
    end else begin
      if (ex) begin
        case (ins[5:3])
          3'd0: m_pc   = v;
          3'd1: m_addr = v;
          3'd3: m_a    = v;
          3'd4: m_b    = v;
          3'd5: m_i    = v;
          3'd6: m_j    = v;
          3'd7: m_k    = v;
          default: ;
        endcase
      end
      if (!(ex && ins[5:3] == 3'd0)) m_pc = m_pc + 1;
      m_last = 1'b0;
      m_ret  = m_ret + 1;
    end
    sb_q.push_back('{m_pc, m_addr, m_i, m_j, m_k, m_ret, m_halt});
  endtask

  // Monitor: a completion shows up as a retired step or a halted rise.
  logic [DW-1:0] mon_prev_ret = '0;
  logic          mon_prev_halt = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      mon_prev_ret  = '0;
      mon_prev_halt = 1'b0;
    end else begin
      if (bus.retired !== mon_prev_ret || (bus.halted && !mon_prev_halt)) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_completion: got retired=%h halted=%b expected no completion",
                   bus.retired, bus.halted);
        end else begin
          e = sb_q.pop_front();
          chk("sb_pc", bus.cnt_pc, e.pc);
          chk("sb_addr", bus.reg_addr, e.addr);
          chk("sb_i", bus.reg_i, e.i);
          chk("sb_j", bus.reg_j, e.j);
          chk("sb_k", bus.reg_k, e.k);
          chk("sb_retired", bus.retired, e.ret);
          chk("sb_halted", DW'(bus.halted), DW'(e.halted));
        end
      end
      mon_prev_ret  = bus.retired;
      mon_prev_halt = bus.halted;
    end
  end

  task automatic issue(input logic [7:0] ins, input int waits_req, input logic [DW-1:0] din,
                       input logic sns);
    logic [DW-1:0] v;
    logic f, ex, mem, ere, ewe;
    int waits;
    bus.alu_x      = $urandom;
    bus.alu_y      = $urandom;
    bus.data_in    = din;
    bus.sense      = sns;
    bus.irom_in    = ins;
    bus.irom_valid = 1'b1;
    bus.run_en     = 1'b1;
    v   = ref_src(ins[2:0], din, bus.alu_x, bus.alu_y);
    f   = m_imm[3] ? (ref_alu(m_a, m_b, bus.alu_x, bus.alu_y, m_imm[2:0]) == '0) : sns;
    ex  = !ins[7] && (!ins[6] || f);
    mem = ex && (ins[2:0] == 3'd2 || ins[5:3] == 3'd2);
    ere = mem && ins[2:0] == 3'd2;
    ewe = mem && ins[5:3] == 3'd2;
    waits = mem ? waits_req : 0;
    bus.dram_ack = (waits == 0);
    @(negedge clk);
    chk("dram_re", DW'(bus.dram_re), DW'(ere));
    chk("dram_we", DW'(bus.dram_we), DW'(ewe));
    if (!ins[7]) chk("data_out", bus.data_out, v);
    for (int w = 1; w <= waits; w++) begin
      @(posedge clk); #1;
      bus.dram_ack   = (w == waits);
      bus.sense      = ~sns;
      bus.irom_in    = 8'($urandom);
      bus.irom_valid = 1'($urandom);
      bus.run_en     = 1'($urandom);
      @(negedge clk);
      chk("wait_re", DW'(bus.dram_re), DW'(ere));
      chk("wait_we", DW'(bus.dram_we), DW'(ewe));
      chk("wait_pc", bus.cnt_pc, m_pc);
    end
    @(posedge clk);
    model_commit(ins, ex, v);
    #1;
    bus.irom_valid = 1'b0;
    bus.dram_ack   = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int g = 0; g < n; g++) begin
      bus.irom_in  = 8'($urandom);
      bus.dram_ack = 1'($urandom);
      bus.sense    = 1'($urandom);
      case ($urandom_range(0, 2))
        0: begin bus.irom_valid = 1'b0; bus.run_en = 1'b1; end
        1: begin bus.irom_valid = 1'b1; bus.run_en = 1'b0; end
        default: begin bus.irom_valid = 1'b0; bus.run_en = 1'b0; end
      endcase
      @(negedge clk);
      chk("gap_re", DW'(bus.dram_re), '0);
      chk("gap_we", DW'(bus.dram_we), '0);
      chk("gap_pc", bus.cnt_pc, m_pc);
      @(posedge clk); #1;
    end
    bus.irom_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.run_en     = 1'b0;
    bus.irom_valid = 1'b0;
    bus.dram_ack   = 1'b0;
    #1;
    model_reset();
    chk("rst_pc", bus.cnt_pc, '0);
    chk("rst_addr", bus.reg_addr, '0);
    chk("rst_i", bus.reg_i, '0);
    chk("rst_j", bus.reg_j, '0);
    chk("rst_k", bus.reg_k, '0);
    chk("rst_retired", bus.retired, '0);
    chk("rst_halted", DW'(bus.halted), '0);
    chk("rst_re", DW'(bus.dram_re), '0);
    chk("rst_we", DW'(bus.dram_we), '0);
    @(negedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.run_en = 1'b0; bus.irom_in = '0; bus.irom_valid = 1'b0; bus.data_in = '0;
    bus.dram_ack = 1'b0; bus.sense = 1'b0; bus.alu_x = '0; bus.alu_y = '0;
    model_reset();
    do_reset();

    // IMM chain into I
    issue(8'h81, 0, '0, 1'b0);
    issue(8'h82, 0, '0, 1'b0);
    issue(8'h2B, 0, '0, 1'b0);
    chk("chain_i", bus.reg_i, 32'h82);
    chk("chain_retired", bus.retired, 32'd3);
    chk("chain_pc", bus.cnt_pc, 32'd3);

    // ADDR=0x10, then a RAM write with three wait cycles
    issue(8'h90, 0, '0, 1'b0);
    issue(8'h0B, 0, '0, 1'b0);
    chk("addr_set", bus.reg_addr, 32'h10);
    issue(8'h15, 3, 32'h5A5A_0001, 1'b0);
    chk("ws_pc", bus.cnt_pc, 32'd6);
    chk("ws_retired", bus.retired, 32'd6);

    // CMOV RAM->J taken on entry with sense flipped during the wait, then a skipped CMOV
    issue(8'h72, 2, 32'hCAFE_1234, 1'b1);
    chk("cmov_latched_j", bus.reg_j, 32'hCAFE_1234);
    issue(8'h72, 0, 32'h1111_1111, 1'b0);
    chk("cmov_skip_j", bus.reg_j, 32'hCAFE_1234);
    chk("cmov_skip_retired", bus.retired, 32'd8);

    // IMM chain survives fetch gaps
    issue(8'h85, 0, '0, 1'b0);
    gap(2);
    issue(8'h86, 0, '0, 1'b0);
    issue(8'h33, 0, '0, 1'b0);
    chk("gap_chain_j", bus.reg_j, 32'h286);

    // PC wrap: all-ones immediate into PC, then one more instruction
    for (int s = 0; s < 6; s++) issue(8'hFF, 0, '0, 1'b0);
    issue(8'h03, 0, '0, 1'b0);
    chk("pc_max", bus.cnt_pc, 32'hFFFF_FFFF);
    issue(8'h35, 0, '0, 1'b0);
    chk("pc_wrap", bus.cnt_pc, 32'h0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
      issue(8'($urandom_range(1, 255)), $urandom_range(0, 3), $urandom, 1'($urandom));
    end

    // Halt and recovery
    issue(8'h00, 0, '0, 1'b0);
    chk("halt_flag", DW'(bus.halted), 32'd1);
    for (int h = 0; h < 3; h++) begin
      bus.irom_in = 8'h12; bus.irom_valid = 1'b1; bus.run_en = 1'b1; bus.dram_ack = 1'b1;
      @(negedge clk);
      chk("halt_re", DW'(bus.dram_re), '0);
      chk("halt_we", DW'(bus.dram_we), '0);
      chk("halt_pc", bus.cnt_pc, m_pc);
      chk("halt_retired", bus.retired, m_ret);
      chk("halt_hold", DW'(bus.halted), 32'd1);
      @(posedge clk); #1;
    end
    do_reset();
    issue(8'h81, 0, '0, 1'b0);
    chk("post_halt_pc", bus.cnt_pc, 32'd1);

    // Async reset in the middle of a RAM->RAM wait
    bus.irom_in = 8'h12; bus.irom_valid = 1'b1; bus.run_en = 1'b1; bus.dram_ack = 1'b0;
    bus.data_in = 32'h0BAD_F00D;
    @(posedge clk); #1;
    bus.irom_valid = 1'b0;
    chk("wait_entry_re", DW'(bus.dram_re), 32'd1);
    chk("wait_entry_we", DW'(bus.dram_we), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_re", DW'(bus.dram_re), '0);
    chk("arst_we", DW'(bus.dram_we), '0);
    chk("arst_pc", bus.cnt_pc, '0);
    chk("arst_halted", DW'(bus.halted), '0);
    model_reset();
    @(negedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;
    issue(8'h81, 0, '0, 1'b0);
    chk("arst_run_retired", bus.retired, 32'd1);
    chk("arst_run_pc", bus.cnt_pc, 32'd1);

    repeat (2) @(posedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1);
  end
endmodule
